ex_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the execute stage of the 5-stage MIPS core (IF/ID/EX/MEM/WB).
- Detects load-use hazards between ID and EX and inserts bubbles.
- Flushes younger stages when a branch or jump resolves taken in MEM.
- Runs a multi-cycle wait FSM that freezes the front of the pipe while an iterative mul/div unit attached to EX completes. Also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/ex_hazard_ctrl_pkg.sv | 31 +++
 rtl/ex_hazard_ctrl_md_wait_timer.sv | 49 ++++
 rtl/ex_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_hazard_ctrl_pkg.sv
// rtl/ex_hazard_ctrl_pkg.sv - shared pipeline-control constants and hazard helpers
package ex_hazard_ctrl_pkg;

   // Sequencer state encoding, also used by the ID/EX and EX/MEM control decode
   localparam logic [0:0] ST_RUN     = 1'b0;
   localparam logic [0:0] ST_MD_WAIT = 1'b1;

   // $zero never carries a real dependency
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Control-flow change resolved in MEM: taken branch or jump
   function automatic logic is_redirect(
      input logic branch,
      input logic aluzero,
      input logic jump
   );
      return (branch & aluzero) | jump;
   endfunction

   // Load in EX whose destination feeds a source operand of the instruction in ID
   function automatic logic is_loaduse(
      input logic       memread,
      input logic [4:0] rd,
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic       uses_rt
   );
      return memread & (rd != REG_ZERO) & ((rd == rs) | (uses_rt & (rd == rt)));
   endfunction

endpackage

// File: rtl/ex_hazard_ctrl_md_wait_timer.sv
// rtl/ex_hazard_ctrl_md_wait_timer.sv - mul/div wait counter, timeout compare and sticky error
module ex_hazard_ctrl_md_wait_timer
   import ex_hazard_ctrl_pkg::*;
#(
   parameter int MD_TIMEOUT = 64
)(
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic md_done,
   output logic timeout,
   output logic md_release,
   output logic md_error
);

   // Wide enough to hold MD_TIMEOUT-1 even for a timeout of 1
   localparam int CW = $clog2(MD_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(MD_TIMEOUT - 1);

   logic [CW-1:0] count;
   logic          at_last;

   assign at_last = (count == LAST);

   // A done pulse on the last allowed cycle wins over the timeout
   assign timeout    = active & ~md_done & at_last;
   assign md_release = active & (md_done | at_last);

   // Count cycles spent waiting; idle or releasing returns the counter to zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (!active || md_release) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   // Sticky error flag, only reset clears it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         md_error <= 1'b0;
      end else if (timeout) begin
         md_error <= 1'b1;
      end
   end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - execute-stage hazard, flush and mul/div wait sequencer
module ex_hazard_ctrl
   import ex_hazard_ctrl_pkg::*;
#(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 16
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rd,
   input  logic             ex_muldiv,
   input  logic             mem_branch,
   input  logic             mem_aluzero,
   input  logic             mem_jump,
   input  logic             md_done,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_bubble,
   output logic             ifid_flush,
   output logic             exmem_bubble,
   output logic             ex_hold,
   output logic             md_start,
   output logic             md_error,
   output logic [CNT_W-1:0] stall_count
);

   logic [0:0] state;
   logic [0:0] next_state;
   logic       redirect;
   logic       loaduse;
   logic       md_active;
   logic       md_timeout;
   logic       md_release;
   logic       md_launch;

   assign redirect  = is_redirect(mem_branch, mem_aluzero, mem_jump);
   assign loaduse   = is_loaduse(ex_memread, ex_rd, id_rs, id_rt, id_uses_rt);
   assign md_active = (state == ST_MD_WAIT);

   // A taken redirect squashes the mul/div in EX, so it never launches
   assign md_launch = (state == ST_RUN) & ~redirect & ex_muldiv;

   ex_hazard_ctrl_md_wait_timer #(
      .MD_TIMEOUT (MD_TIMEOUT)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .active     (md_active),
      .md_done    (md_done),
      .timeout    (md_timeout),
      .md_release (md_release),
      .md_error   (md_error)
   );

   // Pipeline control outputs and next state, all zero-latency from the current inputs
   always_comb begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_bubble  = 1'b0;
      ifid_flush   = 1'b0;
      exmem_bubble = 1'b0;
      ex_hold      = 1'b0;
      next_state   = state;
      case (state)
         ST_RUN: begin
            if (redirect) begin
               ifid_flush   = 1'b1;
               idex_bubble  = 1'b1;
               exmem_bubble = 1'b1;
               pc_write     = 1'b1;
               ifid_write   = 1'b1;
            end else if (ex_muldiv) begin
               ex_hold      = 1'b1;
               exmem_bubble = 1'b1;
               next_state   = ST_MD_WAIT;
            end else if (loaduse) begin
               // The load moves to MEM next edge, so this stalls exactly once
               idex_bubble  = 1'b1;
            end else begin
               pc_write     = 1'b1;
               ifid_write   = 1'b1;
            end
         end
         default: begin
            // MEM only holds bubbles while waiting, so redirect is not consulted
            if (md_release) begin
               pc_write     = 1'b1;
               ifid_write   = 1'b1;
               next_state   = ST_RUN;
            end else begin
               ex_hold      = 1'b1;
               exmem_bubble = 1'b1;
            end
         end
      endcase
   end

   // Sequencer state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_RUN;
      end else begin
         state <= next_state;
      end
   end

   // Start pulse lands in the first wait cycle only
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         md_start <= 1'b0;
      end else begin
         md_start <= md_launch;
      end
   end

   // Saturating count of cycles in which the PC did not advance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count <= '0;
      end else if (!pc_write && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + 1'b1;
      end
   end

   // Timeout is reported through md_error; the local copy is kept for observability
   logic md_timeout_seen;
   assign md_timeout_seen = md_timeout;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb/tb_ex_hazard_ctrl.sv - scoreboard bench for ex_hazard_ctrl
module tb_ex_hazard_ctrl;

   localparam int TMO = 8;
   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [4:0]    id_rs, id_rt, ex_rd;
   logic          id_uses_rt, ex_memread, ex_muldiv;
   logic          mem_branch, mem_aluzero, mem_jump, md_done;
   logic          pc_write, ifid_write, idex_bubble, ifid_flush;
   logic          exmem_bubble, ex_hold, md_start, md_error;
   logic [CW-1:0] stall_count;

   ex_hazard_ctrl #(.MD_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rt   (id_uses_rt),
      .ex_memread   (ex_memread),
      .ex_rd        (ex_rd),
      .ex_muldiv    (ex_muldiv),
      .mem_branch   (mem_branch),
      .mem_aluzero  (mem_aluzero),
      .mem_jump     (mem_jump),
      .md_done      (md_done),
      .pc_write     (pc_write),
      .ifid_write   (ifid_write),
      .idex_bubble  (idex_bubble),
      .ifid_flush   (ifid_flush),
      .exmem_bubble (exmem_bubble),
      .ex_hold      (ex_hold),
      .md_start     (md_start),
      .md_error     (md_error),
      .stall_count  (stall_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          pc_write;
      logic          ifid_write;
      logic          idex_bubble;
      logic          ifid_flush;
      logic          exmem_bubble;
      logic          ex_hold;
      logic          md_start;
      logic          md_error;
      logic [CW-1:0] stall_count;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   logic m_state, m_start, m_err;
   int   m_cnt, m_scnt;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
      ex_memread = 1'b0; ex_rd = 5'd0; ex_muldiv = 1'b0;
      mem_branch = 1'b0; mem_aluzero = 1'b0; mem_jump = 1'b0; md_done = 1'b0;
   endtask

   task automatic model_reset();
      m_state = 1'b0; m_start = 1'b0; m_err = 1'b0; m_cnt = 0; m_scnt = 0;
      sb_q.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   // One clock: predict from current inputs, compare mid-cycle, then advance the model
   task automatic cycle(input string tag);
      exp_t e, q;
      logic redir, lu, to, rel, nxt;
      redir = (mem_branch & mem_aluzero) | mem_jump;
      lu = ex_memread && (ex_rd != 5'd0) && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
      e = '0;
      e.md_start = m_start;
      e.md_error = m_err;
      e.stall_count = CW'(m_scnt);
      nxt = m_state;
      to = 1'b0;
      rel = 1'b0;
      if (!m_state) begin
         if (redir) begin
            e.pc_write = 1; e.ifid_write = 1; e.ifid_flush = 1; e.idex_bubble = 1; e.exmem_bubble = 1;
         end else if (ex_muldiv) begin
            e.ex_hold = 1; e.exmem_bubble = 1; nxt = 1'b1;
         end else if (lu) begin
            e.idex_bubble = 1;
         end else begin
            e.pc_write = 1; e.ifid_write = 1;
         end
      end else begin
         to = !md_done && (m_cnt == TMO - 1);
         rel = md_done || (m_cnt == TMO - 1);
         if (rel) begin
            e.pc_write = 1; e.ifid_write = 1; nxt = 1'b0;
         end else begin
            e.ex_hold = 1; e.exmem_bubble = 1;
         end
      end
      sb_q.push_back(e);
      #4;
      q = sb_q.pop_front();
      check_val({tag, ".pc_write"},     32'(pc_write),     32'(q.pc_write));
      check_val({tag, ".ifid_write"},   32'(ifid_write),   32'(q.ifid_write));
      check_val({tag, ".idex_bubble"},  32'(idex_bubble),  32'(q.idex_bubble));
      check_val({tag, ".ifid_flush"},   32'(ifid_flush),   32'(q.ifid_flush));
      check_val({tag, ".exmem_bubble"}, 32'(exmem_bubble), 32'(q.exmem_bubble));
      check_val({tag, ".ex_hold"},      32'(ex_hold),      32'(q.ex_hold));
      check_val({tag, ".md_start"},     32'(md_start),     32'(q.md_start));
      check_val({tag, ".md_error"},     32'(md_error),     32'(q.md_error));
      check_val({tag, ".stall_count"},  32'(stall_count),  32'(q.stall_count));
      @(posedge clk);
      m_start = !m_state && !redir && ex_muldiv;
      if (m_state) begin
         m_cnt = rel ? 0 : m_cnt + 1;
         if (to) m_err = 1'b1;
      end
      if (!e.pc_write && m_scnt != SAT) m_scnt++;
      m_state = nxt;
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;

      cycle("rst");

      ex_memread = 1; ex_rd = 5'd8; id_rs = 5'd8;
      cycle("lu_rs");
      idle();
      cycle("lu_after");
      check_val("lu_cnt", 32'(stall_count), 32'd1);

      ex_memread = 1; ex_rd = 5'd0; id_rs = 5'd0;
      cycle("lu_r0");
      ex_memread = 1; ex_rd = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1;
      cycle("lu_rt");
      id_uses_rt = 0;
      cycle("lu_rt_unused");
      ex_memread = 0; ex_rd = 5'd8; id_rs = 5'd8;
      cycle("no_memread");
      idle();

      do_reset();
      ex_muldiv = 1;
      cycle("md_go");
      idle();
      for (int i = 0; i < 4; i++) cycle("md_wait");
      md_done = 1;
      cycle("md_done");
      idle();
      cycle("md_back");
      check_val("md_cnt", 32'(stall_count), 32'd5);
      md_done = 1;
      cycle("md_done_run");
      idle();

      mem_branch = 1; mem_aluzero = 1; ex_muldiv = 1; ex_memread = 1; ex_rd = 5'd5; id_rs = 5'd5;
      cycle("redir");
      idle();
      cycle("redir_after");
      mem_jump = 1; ex_muldiv = 1;
      cycle("jump");
      idle();
      mem_branch = 1; ex_muldiv = 1;
      cycle("br_not_taken");
      idle();
      mem_jump = 1;
      cycle("redir_in_wait");
      idle();
      cycle("wait2");
      md_done = 1;
      cycle("wait_done");
      idle();

      do_reset();
      ex_muldiv = 1;
      cycle("co_go");
      idle();
      for (int i = 0; i < TMO - 1; i++) cycle("co_wait");
      md_done = 1;
      cycle("co_done");
      idle();
      cycle("co_back");
      check_val("co_err", 32'(md_error), 32'd0);

      ex_muldiv = 1;
      cycle("to_go");
      idle();
      for (int i = 0; i < TMO; i++) cycle("to_wait");
      cycle("to_back");
      check_val("to_err", 32'(md_error), 32'd1);
      check_val("sat", 32'(stall_count), 32'(SAT));

      ex_muldiv = 1;
      cycle("rs_go");
      idle();
      cycle("rs_w1");
      cycle("rs_w2");
      #3;
      check_val("pre_rst_hold", 32'(ex_hold), 32'd1);
      reset = 1'b1;
      #1;
      check_val("rst_pc_write", 32'(pc_write), 32'd1);
      check_val("rst_ex_hold", 32'(ex_hold), 32'd0);
      check_val("rst_md_error", 32'(md_error), 32'd0);
      check_val("rst_stall_count", 32'(stall_count), 32'd0);
      reset = 1'b0;
      model_reset();
      @(posedge clk);
      #1;

      ex_muldiv = 1;
      cycle("st_go");
      idle();
      #3;
      check_val("pre_rst_start", 32'(md_start), 32'd1);
      reset = 1'b1;
      #1;
      check_val("rst_md_start", 32'(md_start), 32'd0);
      reset = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      cycle("final");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
